// File: rtl/switch_rd_arbiter.sv
// rtl/switch_rd_arbiter.sv - round-robin burst read arbiter for one switch output port
module switch_rd_arbiter #(
  parameter int PORT_NUB   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4,
  localparam int WIDTH_SEL = $clog2(PORT_NUB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_NUB-1:0]   empty,
  output logic [WIDTH_SEL-1:0]  rd_sel,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [WIDTH_SEL-1:0]  out_src
);

  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0]    BURST_MAX = BCNT_W'(MAX_BURST);
  localparam logic [WIDTH_SEL-1:0] LAST_SRC  = WIDTH_SEL'(PORT_NUB - 1);

  typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;

  state_t                state, state_n;
  logic [WIDTH_SEL-1:0]  rr_ptr, rr_n;
  logic [WIDTH_SEL-1:0]  cur_src, cur_n;
  logic [BCNT_W-1:0]     burst_cnt, burst_n;
  logic [WIDTH_SEL-1:0]  rd_sel_q;
  logic                  inflight;
  logic [WIDTH_SEL-1:0]  inflight_src;
  logic                  found;
  logic [WIDTH_SEL-1:0]  grant_idx;
  logic [WIDTH_SEL-1:0]  next_ptr;
  logic                  credit;

  logic [DATA_WIDTH-1:0] mem_data [2];
  logic [WIDTH_SEL-1:0]  mem_src  [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            occ;
  logic                  push, pop;

  // Credit counts the word already on its way back so the 2-entry buffer can never overflow.
  assign credit   = (occ == 2'd0) || ((occ == 2'd1) && !inflight);
  assign next_ptr = (cur_src == LAST_SRC) ? '0 : cur_src + 1'b1;
  assign rd_sel   = rd_en ? cur_src : rd_sel_q;

  always_comb begin
    int idx;
    found     = 1'b0;
    grant_idx = rr_ptr;
    for (int k = 0; k < PORT_NUB; k++) begin
      idx = (int'(rr_ptr) + k) % PORT_NUB;
      if (!found && !empty[idx]) begin
        found     = 1'b1;
        grant_idx = idx[WIDTH_SEL-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    burst_n = burst_cnt;
    cur_n   = cur_src;
    rr_n    = rr_ptr;
    case (state)
      IDLE: if (!(&empty)) state_n = GRANT;
      GRANT: begin
        if (found) begin
          cur_n   = grant_idx;
          burst_n = '0;
          state_n = BURST;
        end else begin
          state_n = IDLE;
        end
      end
      BURST: begin
        if (empty[cur_src]) begin
          state_n = GRANT;
          rr_n    = next_ptr;
        end else if (credit) begin
          rd_en   = 1'b1;
          burst_n = burst_cnt + 1'b1;
          if (burst_n == BURST_MAX) begin
            state_n = GRANT;
            rr_n    = next_ptr;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_src      <= '0;
      burst_cnt    <= '0;
      rd_sel_q     <= '0;
      inflight     <= 1'b0;
      inflight_src <= '0;
    end else begin
      state        <= state_n;
      rr_ptr       <= rr_n;
      cur_src      <= cur_n;
      burst_cnt    <= burst_n;
      inflight     <= rd_en;
      inflight_src <= rd_sel;
      if (rd_en) rd_sel_q <= cur_src;
    end
  end

  assign push      = inflight;
  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_src   = mem_src[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_src[i]  <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= data_in;
        mem_src[wr_ptr]  <= inflight_src;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_rd_arbiter.sv
// tb/tb_switch_rd_arbiter.sv - randomized bench for switch_rd_arbiter against a queue model
module tb_switch_rd_arbiter;
  localparam int P  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [P-1:0]  empty;
  logic [1:0]    rd_sel;
  logic          rd_en;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;

  switch_rd_arbiter #(.PORT_NUB(P), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .empty(empty), .rd_sel(rd_sel), .rd_en(rd_en),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int q[P][$];
  int exp_rd[$];
  int exp_out[$];
  int model_ptr = 0;
  int ready_mode = 0;
  int reads_seen = 0;
  int words_out = 0;
  int nxt_data = 0;
  bit have_data = 0;

  function automatic void update_empty();
    for (int i = 0; i < P; i++) empty[i] = (q[i].size() == 0);
  endfunction

  function automatic void load(input int s, input int n);
    repeat (n) q[s].push_back(int'($urandom_range(1, 65535)));
  endfunction

  // Expected read order from the queue lengths alone: round robin from the pointer, up to MB words each turn.
  function automatic void plan();
    int len[P];
    int s, n, left;
    for (int i = 0; i < P; i++) len[i] = q[i].size();
    while (1) begin
      left = 0;
      for (int i = 0; i < P; i++) left += len[i];
      if (left == 0) break;
      s = model_ptr;
      while (len[s] == 0) s = (s + 1) % P;
      n = (len[s] < MB) ? len[s] : MB;
      repeat (n) exp_rd.push_back(s);
      len[s] -= n;
      model_ptr = (s + 1) % P;
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < P; i++) q[i].delete();
    exp_rd.delete();
    exp_out.delete();
    have_data = 0;
  endfunction

  always @(posedge clk) begin
    have_data = 0;
    if (!rst) begin
      if (rd_en) begin
        reads_seen++;
        checks++;
        if (exp_rd.size() == 0 || int'(rd_sel) != exp_rd[0]) begin
          failures++;
          $display("FAIL rd_order: rd_sel=%0d required=%0d", rd_sel, (exp_rd.size() == 0) ? -1 : exp_rd[0]);
        end
        if (exp_rd.size() != 0) void'(exp_rd.pop_front());
        checks++;
        if (q[rd_sel].size() == 0) begin
          failures++;
          $display("FAIL rd_on_empty: rd_sel=%0d read while queue empty", rd_sel);
        end else begin
          nxt_data = q[rd_sel].pop_front();
          exp_out.push_back((int'(rd_sel) << 16) | nxt_data);
          have_data = 1;
        end
      end
      if (out_valid && out_ready) begin
        words_out++;
        checks++;
        if (exp_out.size() == 0) begin
          failures++;
          $display("FAIL out_word: got src=%0d data=%h, no word expected", out_src, out_data);
        end else begin
          if (((int'(out_src) << 16) | int'(out_data)) != exp_out[0]) begin
            failures++;
            $display("FAIL out_word: got src=%0d data=%h required src=%0d data=%h",
                     out_src, out_data, exp_out[0] >> 16, exp_out[0] & 16'hffff);
          end
          void'(exp_out.pop_front());
        end
      end
    end
    #1;
    data_in = have_data ? DW'(nxt_data) : DW'($urandom);
    update_empty();
    if (ready_mode != 0) out_ready = 1'($urandom);
  end

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_rd.size() != 0 || exp_out.size() != 0 || out_valid) && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= budget) begin
      failures++;
      $display("FAIL %s_timeout: %0d reads and %0d words outstanding after %0d cycles",
               name, exp_rd.size(), exp_out.size(), c);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    clear_model();
    model_ptr = 0;
    load(2, 3);
    update_empty();
    plan();
    repeat (3) @(negedge clk);
    checks++;
    if (rd_en !== 1'b0 || out_valid !== 1'b0 || rd_sel !== 2'd0 || out_data !== '0 || out_src !== 2'd0) begin
      failures++;
      $display("FAIL reset_values: rd_en=%b out_valid=%b rd_sel=%0d out_data=%h out_src=%0d required all 0",
               rd_en, out_valid, rd_sel, out_data, out_src);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b0) begin failures++; $display("FAIL idle_cycle: rd_en=%b required 0", rd_en); end
    @(posedge clk); #1;
    checks++;
    if (rd_en !== 1'b0) begin failures++; $display("FAIL grant_cycle: rd_en=%b required 0", rd_en); end
    @(posedge clk); #1;
    checks++;
    if (rd_en !== 1'b1 || rd_sel !== 2'd2) begin
      failures++;
      $display("FAIL first_read: rd_en=%b rd_sel=%0d required 1 and 2", rd_en, rd_sel);
    end
    wait_drain("reset", 200);
  endtask

  task automatic test_single_source();
    int w0 = words_out;
    load(1, 10);
    update_empty();
    plan();
    wait_drain("single", 300);
    checks++;
    if (words_out - w0 != 10) begin
      failures++;
      $display("FAIL single_count: got %0d words required 10", words_out - w0);
    end
  endtask

  task automatic test_all_sources();
    int w0 = words_out;
    for (int s = 0; s < P; s++) load(s, 6);
    update_empty();
    plan();
    wait_drain("all", 600);
    checks++;
    if (words_out - w0 != 24) begin
      failures++;
      $display("FAIL all_count: got %0d words required 24", words_out - w0);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    out_ready = 1'b0;
    r0 = reads_seen;
    load(0, 5);
    update_empty();
    plan();
    repeat (12) @(negedge clk);
    checks++;
    if (reads_seen - r0 != 2 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_reads: reads=%0d out_valid=%b required 2 and 1", reads_seen - r0, out_valid);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (reads_seen - r0 != 2) begin
      failures++;
      $display("FAIL stall_hold: reads=%0d required 2", reads_seen - r0);
    end
    out_ready = 1'b1;
    wait_drain("backpressure", 300);
  endtask

  task automatic test_mid_burst_empty();
    load(3, 1);
    load(0, 3);
    update_empty();
    checks++;
    if (model_ptr != 1) begin
      failures++;
      $display("FAIL mid_ptr: model pointer %0d required 1 before this scenario", model_ptr);
    end
    plan();
    wait_drain("mid_burst", 300);
  endtask

  task automatic test_random();
    ready_mode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < P; s++) load(s, int'($urandom_range(0, 9)));
      update_empty();
      plan();
      wait_drain("random", 2000);
    end
    ready_mode = 0;
    @(negedge clk);
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midburst();
    int c = 0;
    load(1, 6);
    update_empty();
    plan();
    while (rd_en !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= 100) begin
      failures++;
      $display("FAIL midreset_wait: no read seen within %0d cycles", c);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    clear_model();
    model_ptr = 0;
    #1;
    checks++;
    if (rd_en !== 1'b0 || out_valid !== 1'b0 || rd_sel !== 2'd0 || out_data !== '0 || out_src !== 2'd0) begin
      failures++;
      $display("FAIL midreset_values: rd_en=%b out_valid=%b rd_sel=%0d out_data=%h out_src=%0d required all 0",
               rd_en, out_valid, rd_sel, out_data, out_src);
    end
    update_empty();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL midreset_discard: out_valid=%b rd_en=%b required 0 and 0", out_valid, rd_en);
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    empty = '1;
    data_in = '0;
    @(negedge clk);
    test_reset();
    test_single_source();
    test_all_sources();
    test_backpressure();
    test_mid_burst_empty();
    test_random();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
